store_drain_buffer: RTL and testbench

STORE_DRAIN_BUFFER -- requirements
Module: store_drain_buffer

---
 rtl/store_buf_pkg.sv | 20 ++
 rtl/sb_fwd_match.sv | 36 +++
 rtl/store_drain_buffer.sv | 127 ++++++++++++
 tb/tb_store_drain_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buf_pkg.sv
// Shared types for the store drain buffer: FSM state encoding and the
// buffered-store entry. SB_AW/SB_DW are the storage widths of one entry;
// the buffer's AW/DW parameters must not exceed them.
package store_buf_pkg;

   localparam int unsigned SB_AW = 32;
   localparam int unsigned SB_DW = 32;

   typedef enum logic [1:0] {
      SB_IDLE     = 2'd0,
      SB_ACTIVE   = 2'd1,
      SB_FLUSHING = 2'd2
   } sb_state_e;

   typedef struct packed {
      logic [SB_AW-1:0] addr;
      logic [SB_DW-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match store-to-load forwarding search.
// Ports: tag (word address being looked up), ent_tag/ent_data/ent_valid
// (buffer contents by slot), wr_ptr (next write slot, so wr_ptr-1 is the
// youngest), fwd_hit/fwd_data (combinational match result).
module sb_fwd_match #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32,
   parameter int unsigned PW    = $clog2(DEPTH)
) (
   input  logic [AW-3:0]    tag,
   input  logic [AW-3:0]    ent_tag  [DEPTH],
   input  logic [DW-1:0]    ent_data [DEPTH],
   input  logic [DEPTH-1:0] ent_valid,
   input  logic [PW-1:0]    wr_ptr,
   output logic             fwd_hit,
   output logic [DW-1:0]    fwd_data
);

   logic [PW-1:0] idx;

   // Walk slots oldest to youngest so the last match written wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         idx = wr_ptr - PW'(k);
         if (ent_valid[idx] && (ent_tag[idx] == tag)) begin
            fwd_hit  = 1'b1;
            fwd_data = ent_data[idx];
         end
      end
   end

endmodule

// File: rtl/store_drain_buffer.sv
// Store drain buffer: queues processor stores and drains them in order to
// backing memory, forwarding the youngest matching store to loads.
// Ports: clk/reset (sync, active-low); memwrite/dataadr/writedata store
// input, stall back-pressure; fwd_hit/fwd_data forwarding result;
// mem_valid/mem_ready/mem_addr/mem_wdata drain handshake; flush/flush_done
// drain-all request and completion pulse; count occupancy.
module store_drain_buffer
   import store_buf_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       memwrite,
   input  logic [AW-1:0]              dataadr,
   input  logic [DW-1:0]              writedata,
   output logic                       stall,
   output logic                       fwd_hit,
   output logic [DW-1:0]              fwd_data,
   output logic                       mem_valid,
   input  logic                       mem_ready,
   output logic [AW-1:0]              mem_addr,
   output logic [DW-1:0]              mem_wdata,
   input  logic                       flush,
   output logic                       flush_done,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   sb_entry_t        ent_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   sb_state_e        state_q;
   logic             flush_done_q;

   logic             push;
   logic             pop;
   logic [CW-1:0]    count_nxt;
   logic [AW-3:0]    ent_tag  [DEPTH];
   logic [DW-1:0]    ent_data [DEPTH];

   // Back-pressure depends only on registered state, never on mem_ready.
   assign stall      = (state_q == SB_FLUSHING) || (count_q == CW'(DEPTH));
   assign mem_valid  = (count_q != '0);
   assign push       = memwrite && !stall;
   assign pop        = mem_valid && mem_ready;
   assign count_nxt  = count_q + CW'(push) - CW'(pop);

   assign mem_addr   = ent_q[rd_ptr_q].addr[AW-1:0];
   assign mem_wdata  = ent_q[rd_ptr_q].data[DW-1:0];
   assign count      = count_q;
   assign flush_done = flush_done_q;

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      assign ent_tag[i]  = ent_q[i].addr[AW-1:2];
      assign ent_data[i] = ent_q[i].data[DW-1:0];
   end

   // Pointers, occupancy, entry storage and FSM.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= SB_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         valid_q      <= '0;
         flush_done_q <= 1'b0;
      end else begin
         flush_done_q <= 1'b0;
         count_q      <= count_nxt;
         if (pop) begin
            valid_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q          <= rd_ptr_q + PW'(1);
         end
         if (push) begin
            ent_q[wr_ptr_q]   <= '{addr: SB_AW'(dataadr), data: SB_DW'(writedata)};
            valid_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q          <= wr_ptr_q + PW'(1);
         end
         unique case (state_q)
            SB_IDLE, SB_ACTIVE: begin
               if (flush) begin
                  // An empty buffer completes the flush immediately.
                  if (count_nxt == '0) begin
                     state_q      <= SB_IDLE;
                     flush_done_q <= 1'b1;
                  end else begin
                     state_q      <= SB_FLUSHING;
                  end
               end else if (count_nxt == '0) begin
                  state_q <= SB_IDLE;
               end else begin
                  state_q <= SB_ACTIVE;
               end
            end
            SB_FLUSHING: begin
               if (count_nxt == '0) begin
                  state_q      <= SB_IDLE;
                  flush_done_q <= 1'b1;
               end
            end
            default: state_q <= SB_IDLE;
         endcase
      end
   end

   sb_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fwd (
      .tag       (dataadr[AW-1:2]),
      .ent_tag   (ent_tag),
      .ent_data  (ent_data),
      .ent_valid (valid_q),
      .wr_ptr    (wr_ptr_q),
      .fwd_hit   (fwd_hit),
      .fwd_data  (fwd_data)
   );

endmodule

// File: tb/tb_store_drain_buffer.sv
// Randomized + directed bench for store_drain_buffer against a queue model.
module tb_store_drain_buffer;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic        stall;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        flush;
   logic        flush_done;
   logic [2:0]  count;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: in-order queue of stores plus flush bookkeeping.
   logic [31:0] m_addr [$];
   logic [31:0] m_data [$];
   bit          m_flushing = 1'b0;
   bit          m_done     = 1'b0;

   store_drain_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .memwrite   (memwrite),
      .dataadr    (dataadr),
      .writedata  (writedata),
      .stall      (stall),
      .fwd_hit    (fwd_hit),
      .fwd_data   (fwd_data),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .flush      (flush),
      .flush_done (flush_done),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic bit m_stall();
      return m_flushing || (m_addr.size() == DEPTH);
   endfunction

   // Compare every output against the model (called mid-cycle).
   task automatic compare_all();
      bit          hit = 1'b0;
      logic [31:0] fd  = '0;
      for (int i = m_addr.size() - 1; i >= 0; i--) begin
         if (!hit && (m_addr[i][31:2] == dataadr[31:2])) begin
            hit = 1'b1;
            fd  = m_data[i];
         end
      end
      check("count", 64'(count), 64'(m_addr.size()));
      check("stall", 64'(stall), 64'(m_stall()));
      check("mem_valid", 64'(mem_valid), 64'(m_addr.size() != 0));
      check("flush_done", 64'(flush_done), 64'(m_done));
      check("fwd_hit", 64'(fwd_hit), 64'(hit));
      if (m_addr.size() != 0) begin
         check("mem_addr", 64'(mem_addr), 64'(m_addr[0]));
         check("mem_wdata", 64'(mem_wdata), 64'(m_data[0]));
      end
      if (hit) check("fwd_data", 64'(fwd_data), 64'(fd));
   endtask

   // Apply one rising edge to the model using the currently driven inputs.
   task automatic model_edge();
      bit push, pop;
      if (!reset) begin
         m_addr.delete();
         m_data.delete();
         m_flushing = 1'b0;
         m_done     = 1'b0;
         return;
      end
      push   = memwrite && !m_stall();
      pop    = (m_addr.size() != 0) && mem_ready;
      m_done = 1'b0;
      if (pop) begin
         void'(m_addr.pop_front());
         void'(m_data.pop_front());
      end
      if (push) begin
         m_addr.push_back(dataadr);
         m_data.push_back(writedata);
      end
      if (m_flushing) begin
         if (m_addr.size() == 0) begin
            m_flushing = 1'b0;
            m_done     = 1'b1;
         end
      end else if (flush) begin
         if (m_addr.size() == 0) m_done = 1'b1;
         else m_flushing = 1'b1;
      end
   endtask

   // Inputs are set after a falling edge; check, clock, advance model.
   task automatic step();
      #1 compare_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      memwrite  = 1'b0;
      flush     = 1'b0;
      mem_ready = 1'b0;
      dataadr   = '0;
      writedata = '0;
   endtask

   // Present a store and hold it until it is accepted (bounded).
   task automatic push_store(input logic [31:0] a, input logic [31:0] d);
      memwrite  = 1'b1;
      dataadr   = a;
      writedata = d;
      for (int t = 0; t < 20 && m_stall(); t++) step();
      check("push_not_stalled", 64'(m_stall()), 64'(0));
      step();
      memwrite = 1'b0;
   endtask

   task automatic drain_all();
      mem_ready = 1'b1;
      for (int t = 0; t < 20 && m_addr.size() != 0; t++) step();
      check("drained", 64'(count), 64'(0));
      mem_ready = 1'b0;
   endtask

   initial begin
      int pulses;
      idle_inputs();
      reset = 1'b0;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      step();
      check("reset_count", 64'(count), 64'(0));
      check("reset_valid", 64'(mem_valid), 64'(0));
      reset = 1'b1;

      // Single store held while memory is busy, then drained.
      push_store(32'h10, 32'hAAAA5555);
      for (int i = 0; i < 5; i++) begin
         check("hold_addr", 64'(mem_addr), 64'h10);
         step();
      end
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      check("pop_count", 64'(count), 64'(0));

      // Fill to full; fifth store enters only after the first pop.
      for (int i = 1; i <= 4; i++) push_store(32'h100 + 32'(4 * i), 32'(i));
      check("full_stall", 64'(stall), 64'(1));
      memwrite  = 1'b1;
      dataadr   = 32'h114;
      writedata = 32'd5;
      step();
      step();
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      step();
      memwrite = 1'b0;
      check("fifth_in", 64'(count), 64'(4));
      mem_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         #1 check("drain_order", 64'(mem_wdata), 64'(i));
         step();
      end
      mem_ready = 1'b0;

      // Youngest-match forwarding with byte offset in the load address.
      push_store(32'h20, 32'h1);
      push_store(32'h24, 32'h2);
      push_store(32'h20, 32'h3);
      dataadr = 32'h22;
      #1 check("fwd_hit_dir", 64'(fwd_hit), 64'(1));
      check("fwd_data_dir", 64'(fwd_data), 64'(3));
      step();

      // Flush with three entries.
      flush     = 1'b1;
      mem_ready = 1'b1;
      step();
      flush  = 1'b0;
      pulses = 0;
      for (int t = 0; t < 10; t++) begin
         #1 if (flush_done) pulses++;
         step();
      end
      check("flush_pulses", 64'(pulses), 64'(1));
      mem_ready = 1'b0;

      // Flush of an empty buffer completes the next cycle.
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1 check("empty_flush", 64'(flush_done), 64'(1));
      step();

      // Reset mid-operation discards pending stores.
      push_store(32'h40, 32'h11);
      push_store(32'h44, 32'h22);
      reset = 1'b0;
      step();
      reset     = 1'b1;
      mem_ready = 1'b1;
      #1 check("rst_valid", 64'(mem_valid), 64'(0));
      step();
      step();
      mem_ready = 1'b0;

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         memwrite  = ($urandom_range(0, 9) < 6);
         mem_ready = ($urandom_range(0, 1) == 1);
         flush     = ($urandom_range(0, 39) == 0);
         reset     = ($urandom_range(0, 149) != 0);
         dataadr   = {24'h0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom)};
         writedata = $urandom;
         step();
      end
      reset = 1'b1;
      idle_inputs();
      drain_all();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
